// File: rtl/bus_trace_pkg.sv
// Shared encodings and record geometry for the Z180 bus trace FIFO.
package bus_trace_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_MEM  = 2'b01,
        MODE_IO   = 2'b10,
        MODE_BOTH = 2'b11
    } trace_mode_e;

    // byte0 layout: {MREQ, IORQ, RD, WR, M1, OVF, 2'b00}
    localparam int B0_MREQ = 7;
    localparam int B0_IORQ = 6;
    localparam int B0_RD   = 5;
    localparam int B0_WR   = 4;
    localparam int B0_M1   = 3;
    localparam int B0_OVF  = 2;

    localparam logic [7:0] RD_EMPTY_BYTE = 8'hFF;

    function automatic int rec_bytes(input int addr_w, input int data_w);
        return 1 + (addr_w + 7) / 8 + data_w / 8;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with occupancy count; push and pop may share an edge.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bus_trace_fifo.sv
// Captures qualifying Z180 bus cycles into a record FIFO and serialises them bytewise.
// Optional address window filter enabled by defining BUS_TRACE_MATCH_EN.
module bus_trace_fifo
    import bus_trace_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   PHI,
    input  logic                   RESET,
    input  logic [ADDR_W-1:0]      A,
    input  logic [DATA_W-1:0]      D,
    input  logic                   MREQ,
    input  logic                   IORQ,
    input  logic                   RD,
    input  logic                   WR,
    input  logic                   M1,
    input  logic [1:0]             MODE,
    input  logic                   STALL,
    input  logic                   STEP,
    input  logic                   RD_REQ,
`ifdef BUS_TRACE_MATCH_EN
    input  logic [ADDR_W-1:0]      MATCH_LO,
    input  logic [ADDR_W-1:0]      MATCH_HI,
`endif
    output logic [7:0]             RD_DATA,
    output logic                   RD_VALID,
    output logic                   RD_LAST,
    output logic                   EMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   WAIT_REQ
);

    localparam int REC_BYTES = rec_bytes(ADDR_W, DATA_W);
    localparam int REC_W     = REC_BYTES * 8;
    localparam int ADDR_PW   = 8 * ((ADDR_W + 7) / 8);
    localparam int IDX_W     = $clog2(REC_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    logic              armed;
    logic              pend_valid;
    logic [7:0]        pend_b0;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              ovf;
    logic              stall_hold;
    logic              step_hold;
    logic [IDX_W-1:0]  rd_idx;

    logic              cycle_active;
    logic              in_range;
    logic              qualify;
    logic              capture;
    logic              accept;
    logic              drop;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [7:0]        cap_b0;
    logic [7:0]        byte0;
    logic [ADDR_PW-1:0] addr_pad;
    logic [REC_W-1:0]  push_rec;
    logic [REC_W-1:0]  head_rec;
    logic [7:0]        head_byte;

`ifdef BUS_TRACE_MATCH_EN
    assign in_range = (A >= MATCH_LO) && (A <= MATCH_HI);
`else
    assign in_range = 1'b1;
`endif

    // A second capture while one is still pending can only be dropped.
    always_comb begin
        cycle_active = !MREQ || !IORQ;
        qualify = in_range &&
                  ((!MREQ && (MODE == MODE_MEM || MODE == MODE_BOTH)) ||
                   (!IORQ && M1 && (MODE == MODE_IO || MODE == MODE_BOTH)));
        capture = armed && cycle_active && (!RD || !WR);
        accept  = capture && qualify && !pend_valid && (!full || STALL);
        drop    = capture && qualify && (pend_valid || (full && !STALL));
        push    = pend_valid && !full;
        pop     = RD_REQ && !empty && (rd_idx == LAST_IDX);
    end

    always_comb begin
        cap_b0          = '0;
        cap_b0[B0_MREQ] = MREQ;
        cap_b0[B0_IORQ] = IORQ;
        cap_b0[B0_RD]   = RD;
        cap_b0[B0_WR]   = WR;
        cap_b0[B0_M1]   = M1;
        byte0           = pend_b0;
        byte0[B0_OVF]   = ovf;
        addr_pad        = '0;
        addr_pad[ADDR_W-1:0] = pend_addr;
        push_rec        = {byte0, addr_pad, pend_data};
        head_byte       = head_rec[REC_W-1 -: 8];
        for (int i = 0; i < REC_BYTES; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                head_byte = head_rec[REC_W-1-8*i -: 8];
            end
        end
    end

    // OVF is stamped at push time, so a drop after the push still survives.
    always_ff @(posedge PHI) begin
        if (RESET) begin
            armed      <= 1'b0;
            pend_valid <= 1'b0;
            pend_b0    <= '0;
            pend_addr  <= '0;
            pend_data  <= '0;
            ovf        <= 1'b0;
            stall_hold <= 1'b0;
            step_hold  <= 1'b0;
        end else begin
            if (!cycle_active) begin
                armed <= 1'b1;
            end else if (capture) begin
                armed <= 1'b0;
            end
            if (accept) begin
                pend_valid <= 1'b1;
                pend_b0    <= cap_b0;
                pend_addr  <= A;
                pend_data  <= D;
            end else if (push) begin
                pend_valid <= 1'b0;
            end
            if (push) begin
                ovf <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            stall_hold <= (accept && full) || (pend_valid && full);
            if (push && STEP) begin
                step_hold <= 1'b1;
            end else if (empty) begin
                step_hold <= 1'b0;
            end
        end
    end

    always_ff @(posedge PHI) begin
        if (RESET) begin
            RD_DATA  <= RD_EMPTY_BYTE;
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
            rd_idx   <= '0;
        end else begin
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
            if (RD_REQ) begin
                RD_VALID <= 1'b1;
                if (empty) begin
                    RD_DATA <= RD_EMPTY_BYTE;
                    RD_LAST <= 1'b1;
                end else begin
                    RD_DATA <= head_byte;
                    if (rd_idx == LAST_IDX) begin
                        RD_LAST <= 1'b1;
                        rd_idx  <= '0;
                    end else begin
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (PHI),
        .reset     (RESET),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head_rec),
        .full      (full),
        .empty     (empty),
        .count     (COUNT)
    );

    assign EMPTY    = empty;
    assign WAIT_REQ = stall_hold | step_hold;

endmodule

// File: tb/tb_bus_trace_fifo.sv
// Bench for bus_trace_fifo: directed scenarios plus randomised traffic against a byte-queue model.
`timescale 1ns/1ps
module tb_bus_trace_fifo;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 4;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int REC_BYTES  = 1 + ADDR_BYTES + DATA_BYTES;

    logic              PHI = 1'b0;
    logic              RESET = 1'b1;
    logic [ADDR_W-1:0] A = '0;
    logic [DATA_W-1:0] D = '0;
    logic              MREQ = 1'b1;
    logic              IORQ = 1'b1;
    logic              RD = 1'b1;
    logic              WR = 1'b1;
    logic              M1 = 1'b1;
    logic [1:0]        MODE = 2'b01;
    logic              STALL = 1'b0;
    logic              STEP = 1'b0;
    logic              RD_REQ = 1'b0;
    logic [7:0]        RD_DATA;
    logic              RD_VALID;
    logic              RD_LAST;
    logic              EMPTY;
    logic [2:0]        COUNT;
    logic              WAIT_REQ;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         model_ovf = 1'b0;
    bit         deferred;

    bus_trace_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .PHI      (PHI),
        .RESET    (RESET),
        .A        (A),
        .D        (D),
        .MREQ     (MREQ),
        .IORQ     (IORQ),
        .RD       (RD),
        .WR       (WR),
        .M1       (M1),
        .MODE     (MODE),
        .STALL    (STALL),
        .STEP     (STEP),
        .RD_REQ   (RD_REQ),
`ifdef BUS_TRACE_MATCH_EN
        .MATCH_LO ('0),
        .MATCH_HI ('1),
`endif
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .RD_LAST  (RD_LAST),
        .EMPTY    (EMPTY),
        .COUNT    (COUNT),
        .WAIT_REQ (WAIT_REQ)
    );

    always #5 PHI = ~PHI;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // The head record may be partly read, so occupancy is the ceiling of bytes/record.
    function automatic int modelCount();
        return (exp_q.size() + REC_BYTES - 1) / REC_BYTES;
    endfunction

    function automatic bit modelQualifies(input bit io, input bit m1);
        bit mem_ok = (MODE == 2'b01 || MODE == 2'b11) && !io;
        bit io_ok  = (MODE == 2'b10 || MODE == 2'b11) && io && m1;
        return mem_ok || io_ok;
    endfunction

    function automatic void modelRecord(input bit io, input bit wr, input bit m1,
                                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        int b0;
        b0 = (int'(io) << 7) | (int'(!io) << 6) | (int'(wr) << 5) | (int'(!wr) << 4)
           | (int'(m1) << 3) | (int'(model_ovf) << 2);
        exp_q.push_back(8'(b0));
        for (int i = ADDR_BYTES - 1; i >= 0; i--) exp_q.push_back(8'(addr >> (8 * i)));
        for (int i = DATA_BYTES - 1; i >= 0; i--) exp_q.push_back(8'(data >> (8 * i)));
        model_ovf = 1'b0;
    endfunction

    // Drives a bus cycle up to just after its capture edge and leaves it frozen there.
    task automatic applyStimulus(input bit io, input bit wr, input bit m1,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                 output bit held);
        @(negedge PHI);
        checkOutput("rd_valid_idle", 32'(RD_VALID), 32'd0);
        A = addr;
        D = data;
        M1 = m1;
        if (io) IORQ = 1'b0;
        else MREQ = 1'b0;
        @(negedge PHI);
        if (wr) WR = 1'b0;
        else RD = 1'b0;
        @(negedge PHI);
        held = 1'b0;
        if (modelQualifies(io, m1)) begin
            if (modelCount() < DEPTH) modelRecord(io, wr, m1, addr, data);
            else if (STALL) held = 1'b1;
            else model_ovf = 1'b1;
        end
        if (!STEP) checkOutput("wait_at_capture", 32'(WAIT_REQ), 32'(held));
    endtask

    task automatic endBusCycle();
        MREQ = 1'b1;
        IORQ = 1'b1;
        RD = 1'b1;
        WR = 1'b1;
        M1 = 1'b1;
        @(negedge PHI);
        checkOutput("count_after_cycle", 32'(COUNT), 32'(modelCount()));
        checkOutput("wait_after_cycle", 32'(WAIT_REQ), 32'(STEP && modelCount() > 0));
    endtask

    task automatic readBytes(input int n);
        logic [7:0] eb;
        bit         el;
        RD_REQ = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge PHI);
            if (exp_q.size() == 0) begin
                eb = 8'hFF;
                el = 1'b1;
            end else begin
                el = (exp_q.size() % REC_BYTES) == 1;
                eb = exp_q.pop_front();
            end
            checkOutput("rd_valid", 32'(RD_VALID), 32'd1);
            checkOutput("rd_data", 32'(RD_DATA), 32'(eb));
            checkOutput("rd_last", 32'(RD_LAST), 32'(el));
            if (i == n - 1) RD_REQ = 1'b0;
        end
        checkOutput("count_after_read", 32'(COUNT), 32'(modelCount()));
        checkOutput("empty_after_read", 32'(EMPTY), 32'(modelCount() == 0));
    endtask

    initial begin
        repeat (3) @(negedge PHI);
        checkOutput("reset_rd_data", 32'(RD_DATA), 32'hFF);
        checkOutput("reset_rd_valid", 32'(RD_VALID), 32'd0);
        checkOutput("reset_rd_last", 32'(RD_LAST), 32'd0);
        checkOutput("reset_empty", 32'(EMPTY), 32'd1);
        checkOutput("reset_count", 32'(COUNT), 32'd0);
        checkOutput("reset_wait", 32'(WAIT_REQ), 32'd0);
        RESET = 1'b0;
        @(negedge PHI);

        $display("[TB] memory capture and readout");
        MODE = 2'b01;
        applyStimulus(1'b0, 1'b1, 1'b1, 20'h12345, 8'hA5, deferred);
        endBusCycle();
        readBytes(REC_BYTES);
        applyStimulus(1'b0, 1'b0, 1'b0, 20'h12345, 8'hA5, deferred);
        endBusCycle();
        readBytes(REC_BYTES);

        $display("[TB] mode filtering");
        applyStimulus(1'b1, 1'b0, 1'b1, 20'h00080, 8'h3C, deferred);
        endBusCycle();
        MODE = 2'b10;
        applyStimulus(1'b1, 1'b0, 1'b1, 20'h00080, 8'h3C, deferred);
        endBusCycle();
        readBytes(REC_BYTES);
        MODE = 2'b11;
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h00038, 8'hFF, deferred);
        endBusCycle();

        $display("[TB] overflow drop");
        MODE = 2'b01;
        STALL = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), deferred);
            endBusCycle();
        end
        readBytes(DEPTH * REC_BYTES);
        applyStimulus(1'b0, 1'b0, 1'b1, 20'hABCDE, 8'h11, deferred);
        endBusCycle();
        readBytes(REC_BYTES);

        $display("[TB] stall on full");
        STALL = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), deferred);
            endBusCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 20'h5A5A5, 8'hC3, deferred);
        checkOutput("stall_deferred", 32'(deferred), 32'd1);
        readBytes(REC_BYTES);
        checkOutput("stall_wait_hold", 32'(WAIT_REQ), 32'd1);
        modelRecord(1'b0, 1'b1, 1'b1, 20'h5A5A5, 8'hC3);
        @(negedge PHI);
        checkOutput("stall_wait_release", 32'(WAIT_REQ), 32'd0);
        checkOutput("stall_count_refill", 32'(COUNT), 32'(DEPTH));
        endBusCycle();
        readBytes(DEPTH * REC_BYTES);
        STALL = 1'b0;

        $display("[TB] single step");
        STEP = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 20'h00F00, 8'h5E, deferred);
        endBusCycle();
        for (int i = 0; i < REC_BYTES; i++) begin
            checkOutput("step_wait_before_read", 32'(WAIT_REQ), 32'd1);
            readBytes(1);
            @(negedge PHI);
        end
        checkOutput("step_wait_release", 32'(WAIT_REQ), 32'd0);
        readBytes(1);

        $display("[TB] reset during hold and partial read");
        applyStimulus(1'b0, 1'b0, 1'b1, 20'h77777, 8'h99, deferred);
        endBusCycle();
        readBytes(2);
        RESET = 1'b1;
        @(negedge PHI);
        checkOutput("rst_wait", 32'(WAIT_REQ), 32'd0);
        checkOutput("rst_count", 32'(COUNT), 32'd0);
        checkOutput("rst_rd_data", 32'(RD_DATA), 32'hFF);
        checkOutput("rst_empty", 32'(EMPTY), 32'd1);
        RESET = 1'b0;
        STEP = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
        @(negedge PHI);
        applyStimulus(1'b0, 1'b1, 1'b0, 20'h0BEEF, 8'h42, deferred);
        endBusCycle();
        readBytes(REC_BYTES);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                readBytes(int'($urandom_range(1, 7)));
            end else begin
                MODE = 2'($urandom_range(0, 3));
                applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                              ADDR_W'($urandom), DATA_W'($urandom), deferred);
                endBusCycle();
            end
        end
        readBytes((DEPTH + 1) * REC_BYTES);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
